// File: rtl/fd_pipe_reg_pkg.sv
// Shared definitions for the fetch/decode boundary and its neighbours.
// Holds the fetch address window, handler PC, exception codes and the nop encoding.
// Also holds the packed D-stage register image used by the F/D pipeline register.
package fd_pipe_reg_pkg;

    localparam logic [31:0] PC_BIAS    = 32'h0000_3000;
    localparam logic [31:0] PC_END     = 32'h0000_6FFC;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    typedef logic [4:0] exc_code_t;

    localparam exc_code_t   EXC_NONE = 5'd0;
    localparam exc_code_t   EXC_ADEL = 5'd4;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    // Everything the D stage sees, captured as one register image.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        exc_code_t   exc_code;
        logic        bd;
        logic        valid;
    } d_stage_t;

endpackage

// File: rtl/fd_pipe_reg_if.sv
// Signal bundle between fetch/hazard/CP0 control and the F/D pipeline register.
// master: control side drives stall/flush/req and F-stage values, reads the D image.
// slave:  the pipeline register consumes the controls and drives the D image.
interface fd_pipe_reg_if;
    import fd_pipe_reg_pkg::*;

    logic        stall;
    logic        flush;
    logic        req;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        d_is_jump;

    logic [31:0] d_pc;
    logic [31:0] d_instr;
    exc_code_t   d_exc_code;
    logic        d_bd;
    logic        d_valid;

    modport master (
        output stall, flush, req, f_pc, f_instr, d_is_jump,
        input  d_pc, d_instr, d_exc_code, d_bd, d_valid
    );

    modport slave (
        input  stall, flush, req, f_pc, f_instr, d_is_jump,
        output d_pc, d_instr, d_exc_code, d_bd, d_valid
    );

endinterface

// File: rtl/fd_pipe_reg_f_exc_check.sv
// Fetch-address exception classifier: flags AdEL on misaligned or out-of-window PC.
// Purely combinational, zero latency; no flow control.
// Ports: f_pc_i (address under test), adel_o (fault flag), exc_code_o (EXC_ADEL or EXC_NONE).
module f_exc_check
    import fd_pipe_reg_pkg::*;
#(
    parameter logic [31:0] LO_ADDR = PC_BIAS,
    parameter logic [31:0] HI_ADDR = PC_END
) (
    input  logic [31:0] f_pc_i,
    output logic        adel_o,
    output exc_code_t   exc_code_o
);

    // Unsigned compares: both operands are logic vectors.
    assign adel_o     = (f_pc_i[1:0] != 2'b00) || (f_pc_i < LO_ADDR) || (f_pc_i > HI_ADDR);
    assign exc_code_o = adel_o ? EXC_ADEL : EXC_NONE;

endmodule

// File: rtl/fd_pipe_reg.sv
// Fetch-to-Decode pipeline register: captures PC/instr, tags AdEL and delay slots.
// Latency one cycle, registered outputs only; rst async and immediate.
// Priority at the edge: req (redirect) > stall (hold) > flush (bubble) > load.
// Ports: clk, rst (async active-high), bus (fd_pipe_reg_if.slave).
module fd_pipe_reg
    import fd_pipe_reg_pkg::*;
#(
    parameter logic [31:0] PC_BIAS_P    = PC_BIAS,
    parameter logic [31:0] PC_END_P     = PC_END,
    parameter logic [31:0] HANDLER_PC_P = HANDLER_PC
) (
    input  logic          clk,
    input  logic          rst,
    fd_pipe_reg_if.slave  bus
);

    logic      adel;
    exc_code_t f_exc_code;
    d_stage_t  d_q;
    d_stage_t  d_d;

    f_exc_check #(
        .LO_ADDR (PC_BIAS_P),
        .HI_ADDR (PC_END_P)
    ) u_f_exc_check (
        .f_pc_i     (bus.f_pc),
        .adel_o     (adel),
        .exc_code_o (f_exc_code)
    );

    always_comb begin
        d_d = d_q;
        if (bus.req) begin
            d_d.pc       = HANDLER_PC_P;
            d_d.instr    = INSTR_NOP;
            d_d.exc_code = EXC_NONE;
            d_d.bd       = 1'b0;
            d_d.valid    = 1'b0;
        end else if (bus.stall) begin
            d_d = d_q;
        end else if (bus.flush) begin
            // Bubble keeps a live PC and BD so an interrupt taken on it
            // reports the correct restart address.
            d_d.pc       = bus.f_pc;
            d_d.instr    = INSTR_NOP;
            d_d.exc_code = EXC_NONE;
            d_d.bd       = bus.d_is_jump;
            d_d.valid    = 1'b0;
        end else begin
            // Faulting fetch: PC is kept for EPC/BadVAddr, instruction squashed.
            d_d.pc       = bus.f_pc;
            d_d.instr    = adel ? INSTR_NOP : bus.f_instr;
            d_d.exc_code = f_exc_code;
            d_d.bd       = bus.d_is_jump;
            d_d.valid    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q.pc       <= PC_BIAS_P;
            d_q.instr    <= INSTR_NOP;
            d_q.exc_code <= EXC_NONE;
            d_q.bd       <= 1'b0;
            d_q.valid    <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign bus.d_pc       = d_q.pc;
    assign bus.d_instr    = d_q.instr;
    assign bus.d_exc_code = d_q.exc_code;
    assign bus.d_bd       = d_q.bd;
    assign bus.d_valid    = d_q.valid;

endmodule

// File: doc/fd_pipe_reg.md
# fd_pipe_reg

Fetch-to-Decode pipeline register of the five-stage MIPS core. It sits directly downstream of the program-counter register. Each cycle it captures the fetched PC and instruction word, classifies fetch-address exceptions, and tags delay-slot instructions. It also holds, bubbles or redirects its contents under hazard-unit and CP0 control, then presents the result to the Decode stage.

## Interface
Parameters:
- `PC_BIAS`, 32'h0000_3000: reset PC and lowest legal fetch address.
- `PC_END`, 32'h0000_6FFC: highest legal fetch address.
- `HANDLER_PC`, 32'h0000_4180: PC loaded on an exception/interrupt request.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  hazard-unit hold of the D stage.
- `flush`  in  1  squash the F instruction into a bubble.
- `req`  in  1  CP0 exception/interrupt request: redirect to handler.
- `f_pc`  in  32  PC of the instruction in F.
- `f_instr`  in  32  instruction word read at `f_pc`.
- `d_is_jump`  in  1  instruction currently in D is a branch/jump; the F instruction is its delay slot.
- `d_pc`  out  32  PC presented to D.
- `d_instr`  out  32  instruction presented to D.
- `d_exc_code`  out  5  fetch exception code: 0 = none, 4 = AdEL.
- `d_bd`  out  1  D instruction is in a branch delay slot.
- `d_valid`  out  1  D holds a real instruction, not a bubble.

## Operation
- Fetch check, combinational on `f_pc`: AdEL when `f_pc[1:0] != 0`, `f_pc < PC_BIAS`, or `f_pc > PC_END`. Comparisons are unsigned 32-bit.
- On AdEL the captured instruction is forced to 32'h0 (nop). `d_pc` keeps the faulting `f_pc` so CP0 can record it as EPC/BadVAddr.
- Edge priority, highest first: `rst`, then `req`, then `stall`, then `flush`, then normal load.
  - `req`: `d_pc`=`HANDLER_PC`, `d_instr`=0, `d_exc_code`=0, `d_bd`=0, `d_valid`=0.
  - `stall`: every output register holds its value.
  - `flush`: `d_pc`=`f_pc`, `d_instr`=0, `d_exc_code`=0, `d_bd`=`d_is_jump`, `d_valid`=0. Keeping a live PC and BD in the bubble gives interrupts taken on it a correct macro-PC.
  - Load: `d_pc`=`f_pc`, `d_instr`=`f_instr` (0 if AdEL), `d_exc_code`=AdEL ? 4 : 0, `d_bd`=`d_is_jump`, `d_valid`=1.
- `d_bd` is sampled from `d_is_jump` in the same cycle as the load. The delay slot of a jump whose own fetch faulted is still tagged BD.

## Timing
- Reset values: `d_pc`=`PC_BIAS`, `d_instr`=0, `d_exc_code`=0, `d_bd`=0, `d_valid`=0.
- `rst` acts immediately, with no clock needed, and overrides everything. Deassertion takes effect at the next rising edge.
- Latency: one cycle from F inputs to D outputs. There is no combinational path from inputs to outputs.
- `req` together with `stall`: `req` wins, so the D stage is redirected even while held.
- `stall` together with `flush`: stall wins and `flush` is ignored that cycle. The hazard unit must hold `flush` asserted until the stall clears.
- A stall of any length keeps outputs bit-identical. The first unstalled edge loads the then-current F inputs.

## Structure
- The shared defines header holds `PC_BIAS`, `PC_END`, `HANDLER_PC`, the exception-code constants `EXC_NONE`=0 and `EXC_ADEL`=4, and the nop encoding. These are shared with the PC register, CP0 and later pipeline registers.
- One combinational sub-module, `f_exc_check`: input `f_pc`; outputs `adel` and `exc_code`. It is reused by the M-stage load-address checker.

## Test plan
- Reset: assert `rst` between edges. Outputs go to 0x3000 / 0 / 0 / 0 / 0 with no clock edge.
- Normal load: `f_pc`=0x3004, `f_instr`=0x2408_0001, `d_is_jump`=1. After one edge, `d_pc`=0x3004, `d_instr`=0x2408_0001, `d_exc_code`=0, `d_bd`=1, `d_valid`=1.
- AdEL: `f_pc`=0x3002 → `d_instr`=0, `d_exc_code`=4, `d_pc`=0x3002. `f_pc`=0x7000 → `d_exc_code`=4. `f_pc`=0x6FFC → `d_exc_code`=0. `f_pc`=0x2FFC → `d_exc_code`=4.
- Stall/flush priority: hold `stall` for 3 cycles while the F inputs change; outputs stay unchanged. Then `stall`+`flush` for 1 cycle: still unchanged. Then `flush` alone: `d_valid`=0, `d_instr`=0, `d_pc`=`f_pc`.
- Request: assert `req` together with `stall` and `f_pc`=0x3010. After the edge, `d_pc`=0x4180, `d_valid`=0, `d_bd`=0, `d_exc_code`=0.
